scan_test_ctrl: RTL and testbench
=================================

Name: scan_test_ctrl

Overview:
Sequencer for the scan-based sequential-to-combinational test flow.
- Per pattern: shifts a stimulus into a mux-D scan chain (pseudo-primary inputs), runs one functional capture cycle, then shifts the captured pseudo-primary outputs back out.
- Compares the unloaded response against an expected vector and keeps pass/fail accounting.
- Sits between the test host/bench and the scan-enabled DUT flops.

Parameters:
- CHAIN_LEN, 2, number of scan flops in the chain (>=1).
- CNT_W, 8, width of the pattern and fail counters.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request one pattern; accepted only in IDLE.
- abort  in  1  cancel the current pattern, return to IDLE.
- pattern_in  in  CHAIN_LEN  stimulus; bit CHAIN_LEN-1 is shifted first.
- expected_in  in  CHAIN_LEN  expected captured response.
- scan_out  in  1  serial output of the last chain flop (index CHAIN_LEN-1).
- scan_en  out  1  1 = chain shifts, 0 = chain captures functional D.
- scan_in  out  1  serial data into chain flop index 0.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a pattern completes.
- pass  out  1  compare result, valid with done, held until the next done.
- response  out  CHAIN_LEN  unloaded response, held until the next done.
- pattern_cnt  out  CNT_W  completed patterns, saturating.
- fail_cnt  out  CNT_W  failed patterns, saturating.

Behaviour:
- Reset (async): state=IDLE, scan_en=0, scan_in=0, busy=0, done=0, pass=0, response=0, both counters=0, internal shift counter=0.
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE:
  - start=1 latches pattern_in into the stimulus shift register and expected_in into the expected register.
  - Next state SHIFT_IN; bit counter cleared.
- SHIFT_IN, exactly CHAIN_LEN cycles:
  - scan_en=1; scan_in = stimulus MSB (registered output).
  - Stimulus register shifts left each cycle.
  - After CHAIN_LEN cycles, chain flop k holds pattern_in[k].
- CAPTURE, exactly 1 cycle: scan_en=0, scan_in=0; the chain loads its functional D.
- SHIFT_OUT, exactly CHAIN_LEN cycles:
  - scan_en=1, scan_in=0.
  - On each edge, the response shift register shifts left with scan_out entering at the LSB.
  - After the last edge, response bit k = captured value of flop k.
- DONE, 1 cycle:
  - done=1; pass=(response==expected); pattern_cnt+1.
  - fail_cnt+1 if !pass.
  - Both counters saturate at all-ones.
  - Next state IDLE.
- Latency: start accepted at edge T; done high during cycle T+2*CHAIN_LEN+2; busy low again the cycle after done.
- start while busy: ignored, with no queuing. start in the same cycle as DONE is also ignored; it is accepted the following cycle.
- abort (any non-IDLE state): IDLE on the next edge with scan_en=0. No done pulse, counters unchanged, response/pass keep their previous values.
- abort and start together in IDLE: abort wins, start is dropped.
- Reset mid-operation: immediate return to reset values, including the counters.
- Outputs scan_en and scan_in are registered (glitch-free into the chain).

Decomposition:
- Shared package dft_pkg:
  - State enum encoding for the five states.
  - Localparam for the shift counter width, $clog2(CHAIN_LEN+1).
- Natural sub-module: scan_shift_reg, a parallel-load/serial-shift register of width CHAIN_LEN. Instantiate it twice: once as the stimulus shifter (parallel load, serial out) and once as the response collector (serial in, parallel out).
- FSM and counters stay in the top.

Test Plan:
Bench chain model, CHAIN_LEN=2: the capture D of flop0 is the current flop1 value and the capture D of flop1 is the current flop0 value (a swap).
1. start, pattern_in=2'b10, expected_in=2'b01 -> scan_in sequence 1,0 with scan_en=1; capture cycle with scan_en=0; response=2'b01, pass=1; done exactly 6 cycles after start accepted; pattern_cnt=1, fail_cnt=0.
2. pattern_in=2'b01, expected_in=2'b11 -> response=2'b10, pass=0, fail_cnt increments to 1.
3. Pulse abort during SHIFT_OUT of pattern 2'b10 -> IDLE next cycle, no done pulse, response/pass/counters keep their scenario-2 values.
4. start held high continuously for 3 patterns -> exactly 3 done pulses; each start accepted one cycle after the previous done; pattern_cnt advances by 3.
5. Assert rst asynchronously mid-SHIFT_IN -> all outputs and counters 0 immediately without waiting for a clock edge; a new start then completes normally.
6. Preload CNT_W=2 and run 5 failing patterns -> pattern_cnt and fail_cnt saturate at 2'b11.

Source files
------------

// File: rtl/dft_pkg.sv
// Shared types and helpers for the scan test sequencer: FSM state encoding and
// the shift-counter width derivation.
package dft_pkg;

  localparam int unsigned DEF_CHAIN_LEN = 2;
  localparam int unsigned DEF_CNT_W     = 8;

  typedef enum logic [2:0] {
    StIdle,
    StShiftIn,
    StCapture,
    StShiftOut,
    StDone
  } state_e;

  // Shift counter must represent 0..chain_len.
  function automatic int unsigned shift_cnt_w(input int unsigned chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/scan_test_ctrl_if.sv
// Host/chain-facing signal bundle of the scan test sequencer.
// The slave modport is the controller; the master modport is the host and scan chain side.
interface scan_test_ctrl_if
  import dft_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int unsigned CNT_W     = DEF_CNT_W
);
    logic                 start;
    logic                 abort;
    logic [CHAIN_LEN-1:0] pattern_in;
    logic [CHAIN_LEN-1:0] expected_in;
    logic                 scan_out;
    logic                 scan_en;
    logic                 scan_in;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [CHAIN_LEN-1:0] response;
    logic [CNT_W-1:0]     pattern_cnt;
    logic [CNT_W-1:0]     fail_cnt;

    modport master (
        output start, abort, pattern_in, expected_in, scan_out,
        input  scan_en, scan_in, busy, done, pass, response, pattern_cnt, fail_cnt
    );

    modport slave (
        input  start, abort, pattern_in, expected_in, scan_out,
        output scan_en, scan_in, busy, done, pass, response, pattern_cnt, fail_cnt
    );

endinterface

// File: rtl/scan_shift_reg.sv
// Parallel-load / serial-shift register; shifts left with ser_in entering at the LSB.
module scan_shift_reg
  import dft_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_CHAIN_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= WIDTH'({q, ser_in});
        end
    end

endmodule

// File: rtl/scan_test_ctrl.sv
// Scan test sequencer: shift stimulus in, capture once, shift response out, compare and
// keep saturating pattern/fail counts.
module scan_test_ctrl
  import dft_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input logic             clk,
    input logic             rst,
    scan_test_ctrl_if.slave bus
);

    localparam int unsigned SHIFT_CNT_W = shift_cnt_w(CHAIN_LEN);
    localparam logic [SHIFT_CNT_W-1:0] LAST_BIT = SHIFT_CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e                 state_q;
    logic [SHIFT_CNT_W-1:0] bit_cnt_q;
    logic                   scan_en_q, scan_in_q, done_q, pass_q;
    logic [CHAIN_LEN-1:0]   expected_q, response_q;
    logic [CNT_W-1:0]       pattern_cnt_q, fail_cnt_q;
    logic [CHAIN_LEN-1:0]   stim_q, resp_q, resp_next;
    logic                   accept, resp_match, unused_stim;

    assign accept      = (state_q == StIdle) && bus.start && !bus.abort;
    assign resp_next   = CHAIN_LEN'({resp_q, bus.scan_out});
    assign resp_match  = (resp_next == expected_q);
    assign unused_stim = ^stim_q;

    // MSB is presented directly at accept, so the shifter holds the remaining bits.
    scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_stim (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .shift    (state_q == StShiftIn),
        .ser_in   (1'b0),
        .load_val (bus.pattern_in << 1),
        .q        (stim_q)
    );

    scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_resp (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b0),
        .shift    (state_q == StShiftOut),
        .ser_in   (bus.scan_out),
        .load_val ('0),
        .q        (resp_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            scan_en_q     <= 1'b0;
            scan_in_q     <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            expected_q    <= '0;
            response_q    <= '0;
            pattern_cnt_q <= '0;
            fail_cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort && state_q != StIdle) begin
                state_q   <= StIdle;
                bit_cnt_q <= '0;
                scan_en_q <= 1'b0;
                scan_in_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (accept) begin
                            expected_q <= bus.expected_in;
                            bit_cnt_q  <= '0;
                            scan_en_q  <= 1'b1;
                            scan_in_q  <= bus.pattern_in[CHAIN_LEN-1];
                            state_q    <= StShiftIn;
                        end
                    end
                    StShiftIn: begin
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            scan_en_q <= 1'b0;
                            scan_in_q <= 1'b0;
                            state_q   <= StCapture;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            scan_in_q <= stim_q[CHAIN_LEN-1];
                        end
                    end
                    StCapture: begin
                        scan_en_q <= 1'b1;
                        scan_in_q <= 1'b0;
                        state_q   <= StShiftOut;
                    end
                    StShiftOut: begin
                        if (bit_cnt_q == LAST_BIT) begin
                            // Results are registered on the final unload edge so they align with done.
                            bit_cnt_q  <= '0;
                            scan_en_q  <= 1'b0;
                            done_q     <= 1'b1;
                            pass_q     <= resp_match;
                            response_q <= resp_next;
                            if (pattern_cnt_q != CNT_MAX) pattern_cnt_q <= pattern_cnt_q + 1'b1;
                            if (!resp_match && fail_cnt_q != CNT_MAX) fail_cnt_q <= fail_cnt_q + 1'b1;
                            state_q    <= StDone;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    StDone:  state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.scan_en     = scan_en_q;
    assign bus.scan_in     = scan_in_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.response    = response_q;
    assign bus.pattern_cnt = pattern_cnt_q;
    assign bus.fail_cnt    = fail_cnt_q;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Directed bench for scan_test_ctrl with a 2-flop swap-capture chain model; a second
// instance with 2-bit counters checks saturation.
module tb_scan_test_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scan_test_ctrl_if #(.CHAIN_LEN(2), .CNT_W(8)) bus ();
    scan_test_ctrl_if #(.CHAIN_LEN(2), .CNT_W(2)) bus_sat ();

    scan_test_ctrl #(.CHAIN_LEN(2), .CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    scan_test_ctrl #(.CHAIN_LEN(2), .CNT_W(2)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_sat)
    );

    assign bus_sat.start       = bus.start;
    assign bus_sat.abort       = bus.abort;
    assign bus_sat.pattern_in  = bus.pattern_in;
    assign bus_sat.expected_in = bus.expected_in;

    // chain[k] is flop k; shift: flop0 <= scan_in, flop1 <= flop0; capture swaps the two.
    logic [1:0] chain, chain_sat;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= '0;
        else if (bus.scan_en) chain <= {chain[0], bus.scan_in};
        else chain <= {chain[0], chain[1]};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain_sat <= '0;
        else if (bus_sat.scan_en) chain_sat <= {chain_sat[0], bus_sat.scan_in};
        else chain_sat <= {chain_sat[0], chain_sat[1]};
    end
    assign bus.scan_out     = chain[1];
    assign bus_sat.scan_out = chain_sat[1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns in the done cycle; lat counts cycles from acceptance (acceptance cycle = 1).
    task automatic run_pattern(input logic [1:0] pat, input logic [1:0] exp, output int lat);
        bus.pattern_in  = pat;
        bus.expected_in = exp;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    int lat;
    int ndone;
    int done_cyc[3];
    int extra;

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.pattern_in  = '0;
        bus.expected_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_scan_en", bus.scan_en, 0);
        check_eq("rst_scan_in", bus.scan_in, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_pass", bus.pass, 0);
        check_eq("rst_response", bus.response, 0);
        check_eq("rst_pattern_cnt", bus.pattern_cnt, 0);
        check_eq("rst_fail_cnt", bus.fail_cnt, 0);
        rst = 1'b0;
        step();

        // 1: pattern 10, expect 01 -> swap capture gives 01, pass
        bus.pattern_in  = 2'b10;
        bus.expected_in = 2'b01;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        check_eq("t1_si0_en", bus.scan_en, 1);
        check_eq("t1_si0_in", bus.scan_in, 1);
        check_eq("t1_busy", bus.busy, 1);
        step();
        check_eq("t1_si1_en", bus.scan_en, 1);
        check_eq("t1_si1_in", bus.scan_in, 0);
        step();
        check_eq("t1_cap_en", bus.scan_en, 0);
        check_eq("t1_cap_in", bus.scan_in, 0);
        step();
        check_eq("t1_so0_en", bus.scan_en, 1);
        check_eq("t1_so0_in", bus.scan_in, 0);
        step();
        check_eq("t1_so1_en", bus.scan_en, 1);
        check_eq("t1_so1_done", bus.done, 0);
        step();
        check_eq("t1_done", bus.done, 1);
        check_eq("t1_pass", bus.pass, 1);
        check_eq("t1_response", bus.response, 2'b01);
        check_eq("t1_pattern_cnt", bus.pattern_cnt, 1);
        check_eq("t1_fail_cnt", bus.fail_cnt, 0);
        step();
        check_eq("t1_done_pulse", bus.done, 0);
        check_eq("t1_busy_after", bus.busy, 0);

        // 2: pattern 01, expect 11 -> response 10, fail
        run_pattern(2'b01, 2'b11, lat);
        check_eq("t2_latency", lat, 6);
        check_eq("t2_response", bus.response, 2'b10);
        check_eq("t2_pass", bus.pass, 0);
        check_eq("t2_pattern_cnt", bus.pattern_cnt, 2);
        check_eq("t2_fail_cnt", bus.fail_cnt, 1);
        step();

        // 3: abort during shift-out
        bus.pattern_in  = 2'b10;
        bus.expected_in = 2'b01;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        check_eq("t3_cap_en", bus.scan_en, 0);
        step();
        check_eq("t3_so_en", bus.scan_en, 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check_eq("t3_busy", bus.busy, 0);
        check_eq("t3_scan_en", bus.scan_en, 0);
        check_eq("t3_done", bus.done, 0);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.done === 1'b1) extra++;
        end
        check_eq("t3_no_done", extra, 0);
        check_eq("t3_response", bus.response, 2'b10);
        check_eq("t3_pass", bus.pass, 0);
        check_eq("t3_pattern_cnt", bus.pattern_cnt, 2);
        check_eq("t3_fail_cnt", bus.fail_cnt, 1);

        // 4: start held high -> back-to-back patterns, 7 cycles apart
        bus.pattern_in  = 2'b10;
        bus.expected_in = 2'b01;
        bus.start       = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40 && ndone < 3; c++) begin
            step();
            if (bus.done === 1'b1) begin
                done_cyc[ndone] = c;
                ndone++;
                if (ndone == 3) bus.start = 1'b0;
            end
        end
        check_eq("t4_ndone", ndone, 3);
        check_eq("t4_gap1", done_cyc[1] - done_cyc[0], 7);
        check_eq("t4_gap2", done_cyc[2] - done_cyc[1], 7);
        check_eq("t4_pass", bus.pass, 1);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.done === 1'b1) extra++;
        end
        check_eq("t4_no_extra_done", extra, 0);
        check_eq("t4_pattern_cnt", bus.pattern_cnt, 5);
        check_eq("t4_fail_cnt", bus.fail_cnt, 1);

        // 5: asynchronous reset mid shift-in
        bus.pattern_in  = 2'b10;
        bus.expected_in = 2'b01;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        check_eq("t5_pre_scan_in", bus.scan_in, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t5_busy", bus.busy, 0);
        check_eq("t5_scan_en", bus.scan_en, 0);
        check_eq("t5_scan_in", bus.scan_in, 0);
        check_eq("t5_pass", bus.pass, 0);
        check_eq("t5_response", bus.response, 0);
        check_eq("t5_pattern_cnt", bus.pattern_cnt, 0);
        check_eq("t5_fail_cnt", bus.fail_cnt, 0);
        check_eq("t5_sat_pattern_cnt", bus_sat.pattern_cnt, 0);
        #1;
        rst = 1'b0;
        step();
        run_pattern(2'b10, 2'b01, lat);
        check_eq("t5_latency", lat, 6);
        check_eq("t5_pass_after", bus.pass, 1);
        check_eq("t5_response_after", bus.response, 2'b01);
        check_eq("t5_pattern_cnt_after", bus.pattern_cnt, 1);
        step();

        // 6: five failing patterns; 2-bit counters saturate
        for (int i = 0; i < 5; i++) begin
            run_pattern(2'b01, 2'b11, lat);
            check_eq("t6_latency", lat, 6);
            check_eq("t6_pass", bus_sat.pass, 0);
            if (i == 0) begin
                check_eq("t6_sat_pattern_cnt_first", bus_sat.pattern_cnt, 2);
                check_eq("t6_sat_fail_cnt_first", bus_sat.fail_cnt, 1);
            end
            step();
        end
        check_eq("t6_sat_pattern_cnt", bus_sat.pattern_cnt, 2'b11);
        check_eq("t6_sat_fail_cnt", bus_sat.fail_cnt, 2'b11);
        check_eq("t6_pattern_cnt", bus.pattern_cnt, 6);
        check_eq("t6_fail_cnt", bus.fail_cnt, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
